difftest_harness_ctrl: RTL and testbench

- Parametrised run controller between the formal/sim top and the SimTop DUT.
- Replaces a fixed one-cycle reset pulse and constant tie-offs with:
  - a programmable DUT reset sequencer;
  - run/exit/timeout state tracking;
  - a committed-step counter with a no-progress watchdog;
  - buffered UART-out capture and UART-in feed FIFOs.
- Instantiated once per harness; drives the DUT reset and UART-in, and observes the DUT difftest outputs.

---
 rtl/difftest_harness_ctrl_if.sv | 64 ++++++
 rtl/difftest_harness_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_difftest_harness_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/difftest_harness_ctrl_if.sv
// Bundle of the DUT-facing and bench-facing signals of the difftest run controller.
// The slave modport is the controller's view; the master modport is the environment's view
// (DUT difftest outputs plus the bench-side UART FIFO access).
interface difftest_harness_ctrl_if #(
    parameter int STEP_W = 64
);
    logic                dut_reset;
    logic [63:0]         difftest_exit;
    logic [STEP_W-1:0]   difftest_step;
    logic                difftest_uart_out_valid;
    logic [7:0]          difftest_uart_out_ch;
    logic                difftest_uart_in_valid;
    logic [7:0]          difftest_uart_in_ch;
    logic                uin_push_valid;
    logic [7:0]          uin_push_ch;
    logic                uin_push_ready;
    logic                uout_pop_valid;
    logic [7:0]          uout_pop_ch;
    logic                uout_pop_ready;
    logic [1:0]          state;
    logic [63:0]         exit_code;
    logic [STEP_W-1:0]   step_count;
    logic                uout_overflow;

    modport slave (
        output dut_reset,
        input  difftest_exit,
        input  difftest_step,
        input  difftest_uart_out_valid,
        input  difftest_uart_out_ch,
        input  difftest_uart_in_valid,
        output difftest_uart_in_ch,
        input  uin_push_valid,
        input  uin_push_ch,
        output uin_push_ready,
        output uout_pop_valid,
        output uout_pop_ch,
        input  uout_pop_ready,
        output state,
        output exit_code,
        output step_count,
        output uout_overflow
    );

    modport master (
        input  dut_reset,
        output difftest_exit,
        output difftest_step,
        output difftest_uart_out_valid,
        output difftest_uart_out_ch,
        output difftest_uart_in_valid,
        input  difftest_uart_in_ch,
        output uin_push_valid,
        output uin_push_ch,
        input  uin_push_ready,
        input  uout_pop_valid,
        input  uout_pop_ch,
        output uout_pop_ready,
        input  state,
        input  exit_code,
        input  step_count,
        input  uout_overflow
    );
endinterface

// File: rtl/difftest_harness_ctrl.sv
// difftest_harness_ctrl: run controller sitting between the sim/formal top and SimTop.
// Sequences the DUT reset, tracks RUN/DONE/TIMEOUT, accumulates committed steps with a
// no-progress watchdog, and buffers UART traffic in both directions.
// Optional macro HARNESS_FORMAL_PROPS_EN embeds immediate assertions and covers.
module difftest_harness_ctrl #(
    parameter int RESET_CYCLES = 1,
    parameter int WDOG_CYCLES  = 4096,
    parameter int STEP_W       = 64,
    parameter int UOUT_DEPTH   = 16,
    parameter int UIN_DEPTH    = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    difftest_harness_ctrl_if.slave bus
);

    localparam int RC_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int WD_W  = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;
    localparam int UO_AW = $clog2(UOUT_DEPTH);
    localparam int UI_AW = $clog2(UIN_DEPTH);

    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               dut_reset_q, dut_reset_d;
    logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic [63:0]        exit_code_q, exit_code_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [STEP_W:0]    step_sum_s;
    logic [STEP_W-1:0]  step_sat_s;
    logic               wdog_hit_s;

    // UART-out FIFO (DUT -> bench)
    logic [7:0]         uo_mem [UOUT_DEPTH];
    logic [UO_AW:0]     uo_wr_q, uo_wr_d, uo_rd_q, uo_rd_d;
    logic               uo_ovf_q, uo_ovf_d;
    logic               uo_full_s, uo_empty_s, uo_push_req_s, uo_push_s, uo_pop_s;

    // UART-in FIFO (bench -> DUT)
    logic [7:0]         ui_mem [UIN_DEPTH];
    logic [UI_AW:0]     ui_wr_q, ui_wr_d, ui_rd_q, ui_rd_d;
    logic               ui_full_s, ui_empty_s, ui_push_s, ui_pop_s;
    logic [7:0]         uin_ch_s;

    // Full/empty from the wrap bit of the read and write pointers.
    always_comb begin
        uo_empty_s = (uo_wr_q == uo_rd_q);
        uo_full_s  = (uo_wr_q[UO_AW] != uo_rd_q[UO_AW]) &&
                     (uo_wr_q[UO_AW-1:0] == uo_rd_q[UO_AW-1:0]);
        ui_empty_s = (ui_wr_q == ui_rd_q);
        ui_full_s  = (ui_wr_q[UI_AW] != ui_rd_q[UI_AW]) &&
                     (ui_wr_q[UI_AW-1:0] == ui_rd_q[UI_AW-1:0]);
    end

    // Saturating step accumulation and watchdog expiry detection.
    always_comb begin
        step_sum_s = {1'b0, step_q} + {1'b0, bus.difftest_step};
        if (step_sum_s[STEP_W]) begin
            step_sat_s = '1;
        end else begin
            step_sat_s = step_sum_s[STEP_W-1:0];
        end
        if (WDOG_CYCLES == 0) begin
            wdog_hit_s = 1'b0;
        end else begin
            wdog_hit_s = (bus.difftest_step == '0) && (wdog_q == WD_LAST);
        end
    end

    // Run-state FSM next state: reset sequencing, step/watchdog tracking, exit latching.
    always_comb begin
        state_d     = state_q;
        dut_reset_d = dut_reset_q;
        rst_cnt_d   = rst_cnt_q;
        wdog_d      = wdog_q;
        exit_code_d = exit_code_q;
        step_d      = step_q;
        case (state_q)
            ST_RESET: begin
                if (rst_cnt_q == RC_LAST) begin
                    state_d     = ST_RUN;
                    dut_reset_d = 1'b0;
                    rst_cnt_d   = '0;
                end else begin
                    dut_reset_d = 1'b1;
                    rst_cnt_d   = rst_cnt_q + RC_W'(1'b1);
                end
            end
            ST_RUN: begin
                dut_reset_d = 1'b0;
                step_d      = step_sat_s;
                if (bus.difftest_step != '0) begin
                    wdog_d = '0;
                end else if (WDOG_CYCLES != 0) begin
                    wdog_d = wdog_q + WD_W'(1'b1);
                end else begin
                    wdog_d = wdog_q;
                end
                // An exit request takes priority over a simultaneous watchdog expiry.
                if (bus.difftest_exit != 64'd0) begin
                    state_d     = ST_DONE;
                    exit_code_d = bus.difftest_exit;
                end else if (wdog_hit_s) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                dut_reset_d = 1'b0;
            end
            default: begin
                state_d     = ST_RESET;
                dut_reset_d = 1'b1;
            end
        endcase
    end

    // FIFO pointer and overflow next state.
    always_comb begin
        uo_push_req_s = bus.difftest_uart_out_valid && (state_q == ST_RUN);
        uo_pop_s      = !uo_empty_s && bus.uout_pop_ready && (state_q != ST_RESET);
        // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
        uo_push_s     = uo_push_req_s && (!uo_full_s || uo_pop_s);
        ui_push_s     = bus.uin_push_valid && !ui_full_s && (state_q != ST_RESET);
        ui_pop_s      = bus.difftest_uart_in_valid && (state_q == ST_RUN) && !ui_empty_s && !reset;

        if (uo_push_s) begin
            uo_wr_d = uo_wr_q + (UO_AW + 1)'(1'b1);
        end else begin
            uo_wr_d = uo_wr_q;
        end
        if (uo_pop_s) begin
            uo_rd_d = uo_rd_q + (UO_AW + 1)'(1'b1);
        end else begin
            uo_rd_d = uo_rd_q;
        end
        if (uo_push_req_s && uo_full_s && !uo_pop_s) begin
            uo_ovf_d = 1'b1;
        end else begin
            uo_ovf_d = uo_ovf_q;
        end
        if (ui_push_s) begin
            ui_wr_d = ui_wr_q + (UI_AW + 1)'(1'b1);
        end else begin
            ui_wr_d = ui_wr_q;
        end
        if (ui_pop_s) begin
            ui_rd_d = ui_rd_q + (UI_AW + 1)'(1'b1);
        end else begin
            ui_rd_d = ui_rd_q;
        end
    end

    // Character returned to the DUT: FIFO head when a request is served, else idle 0xFF.
    always_comb begin
        if (ui_pop_s) begin
            uin_ch_s = ui_mem[ui_rd_q[UI_AW-1:0]];
        end else begin
            uin_ch_s = 8'hFF;
        end
    end

    // Control registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RESET;
            dut_reset_q <= 1'b1;
            rst_cnt_q   <= '0;
            wdog_q      <= '0;
            exit_code_q <= 64'd0;
            step_q      <= '0;
            uo_wr_q     <= '0;
            uo_rd_q     <= '0;
            uo_ovf_q    <= 1'b0;
            ui_wr_q     <= '0;
            ui_rd_q     <= '0;
        end else begin
            state_q     <= state_d;
            dut_reset_q <= dut_reset_d;
            rst_cnt_q   <= rst_cnt_d;
            wdog_q      <= wdog_d;
            exit_code_q <= exit_code_d;
            step_q      <= step_d;
            uo_wr_q     <= uo_wr_d;
            uo_rd_q     <= uo_rd_d;
            uo_ovf_q    <= uo_ovf_d;
            ui_wr_q     <= ui_wr_d;
            ui_rd_q     <= ui_rd_d;
        end
    end

    // FIFO storage writes; contents need no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        if (uo_push_s && !reset) begin
            uo_mem[uo_wr_q[UO_AW-1:0]] <= bus.difftest_uart_out_ch;
        end
        if (ui_push_s && !reset) begin
            ui_mem[ui_wr_q[UI_AW-1:0]] <= bus.uin_push_ch;
        end
    end

    assign bus.dut_reset           = reset | dut_reset_q;
    assign bus.state               = state_q;
    assign bus.exit_code           = exit_code_q;
    assign bus.step_count          = step_q;
    assign bus.uout_overflow       = uo_ovf_q;
    assign bus.uout_pop_valid      = !uo_empty_s;
    assign bus.uout_pop_ch         = uo_mem[uo_rd_q[UO_AW-1:0]];
    assign bus.uin_push_ready      = !ui_full_s;
    assign bus.difftest_uart_in_ch = uin_ch_s;

`ifdef HARNESS_FORMAL_PROPS_EN
    state_e            prev_state_q;
    logic [STEP_W-1:0] prev_step_q;
    logic              prev_valid_q;
    logic [UO_AW:0]    uo_cnt_s;
    logic [UI_AW:0]    ui_cnt_s;

    assign uo_cnt_s = uo_wr_q - uo_rd_q;
    assign ui_cnt_s = ui_wr_q - ui_rd_q;

    // History of the previous cycle for the transition and monotonicity checks.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_valid_q <= 1'b0;
            prev_state_q <= ST_RESET;
            prev_step_q  <= '0;
        end else begin
            prev_valid_q <= 1'b1;
            prev_state_q <= state_q;
            prev_step_q  <= step_q;
        end
    end

    // Invariants and reachability points, inactive while reset is high.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (prev_valid_q && (prev_state_q == ST_DONE || prev_state_q == ST_TIMEOUT)) begin
                assert (state_q == prev_state_q);
            end
            assert ((state_q == ST_RESET) || !dut_reset_q);
            assert (uo_cnt_s <= (UO_AW + 1)'(UOUT_DEPTH));
            assert (ui_cnt_s <= (UI_AW + 1)'(UIN_DEPTH));
            if (prev_valid_q) begin
                assert (step_q >= prev_step_q);
            end
            cover (state_q == ST_DONE);
            cover (state_q == ST_TIMEOUT);
            cover (uo_ovf_q);
            cover (ui_full_s);
        end
    end
`else
    // Property code is compiled only when HARNESS_FORMAL_PROPS_EN is defined.
`endif

endmodule

// File: tb/tb_difftest_harness_ctrl.sv
// Directed bench for difftest_harness_ctrl: a vector table for reset/step/exit/watchdog
// sequencing plus hand-written UART FIFO and mid-run reset sequences.
module tb_difftest_harness_ctrl;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    difftest_harness_ctrl_if #(.STEP_W(64)) bus ();

    difftest_harness_ctrl #(
        .RESET_CYCLES (3),
        .WDOG_CYCLES  (4),
        .STEP_W       (64),
        .UOUT_DEPTH   (4),
        .UIN_DEPTH    (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [63:0] step;
        logic [63:0] ext;
        logic [63:0] st;
        logic [63:0] sc;
        logic [63:0] ec;
        logic [63:0] dr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [63:0] s, logic [63:0] e,
                                logic [63:0] st, logic [63:0] sc, logic [63:0] ec,
                                logic [63:0] dr);
        vec_t v;
        v.rst = r; v.step = s; v.ext = e; v.st = st; v.sc = sc; v.ec = ec; v.dr = dr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    localparam logic [63:0] S_RST = 64'd0;
    localparam logic [63:0] S_RUN = 64'd1;
    localparam logic [63:0] S_DON = 64'd2;
    localparam logic [63:0] S_TMO = 64'd3;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.difftest_exit           = 64'd0;
        bus.difftest_step           = 64'd0;
        bus.difftest_uart_out_valid = 1'b0;
        bus.difftest_uart_out_ch    = 8'h00;
        bus.difftest_uart_in_valid  = 1'b0;
        bus.uin_push_valid          = 1'b0;
        bus.uin_push_ch             = 8'h00;
        bus.uout_pop_ready          = 1'b0;

        // rst, step, exit -> state, step_count, exit_code, dut_reset (after the edge)
        tbl.push_back(mk(1'b1, 64'd0, 64'd0, S_RST, 64'd0, 64'd0, 64'd1));
        tbl.push_back(mk(1'b1, 64'd0, 64'd0, S_RST, 64'd0, 64'd0, 64'd1));
        tbl.push_back(mk(1'b0, 64'd9, 64'd0, S_RST, 64'd0, 64'd0, 64'd1));
        tbl.push_back(mk(1'b0, 64'd9, 64'd0, S_RST, 64'd0, 64'd0, 64'd1));
        tbl.push_back(mk(1'b0, 64'd9, 64'd0, S_RUN, 64'd0, 64'd0, 64'd0));
        tbl.push_back(mk(1'b0, 64'd1, 64'd0, S_RUN, 64'd1, 64'd0, 64'd0));
        tbl.push_back(mk(1'b0, 64'd2, 64'd0, S_RUN, 64'd3, 64'd0, 64'd0));
        tbl.push_back(mk(1'b0, 64'd0, 64'd0, S_RUN, 64'd3, 64'd0, 64'd0));
        tbl.push_back(mk(1'b0, 64'd5, 64'd0, S_RUN, 64'd8, 64'd0, 64'd0));
        tbl.push_back(mk(1'b0, 64'd3, 64'd1, S_DON, 64'd11, 64'd1, 64'd0));
        tbl.push_back(mk(1'b0, 64'd4, 64'd7, S_DON, 64'd11, 64'd1, 64'd0));
        tbl.push_back(mk(1'b0, 64'd0, 64'd0, S_DON, 64'd11, 64'd1, 64'd0));
        tbl.push_back(mk(1'b1, 64'd0, 64'd0, S_RST, 64'd0, 64'd0, 64'd1));
        tbl.push_back(mk(1'b0, 64'd0, 64'd0, S_RST, 64'd0, 64'd0, 64'd1));
        tbl.push_back(mk(1'b0, 64'd0, 64'd0, S_RST, 64'd0, 64'd0, 64'd1));
        tbl.push_back(mk(1'b0, 64'd0, 64'd0, S_RUN, 64'd0, 64'd0, 64'd0));
        tbl.push_back(mk(1'b0, 64'd0, 64'd0, S_RUN, 64'd0, 64'd0, 64'd0));
        tbl.push_back(mk(1'b0, 64'd0, 64'd0, S_RUN, 64'd0, 64'd0, 64'd0));
        tbl.push_back(mk(1'b0, 64'd1, 64'd0, S_RUN, 64'd1, 64'd0, 64'd0));
        tbl.push_back(mk(1'b0, 64'd0, 64'd0, S_RUN, 64'd1, 64'd0, 64'd0));
        tbl.push_back(mk(1'b0, 64'd0, 64'd0, S_RUN, 64'd1, 64'd0, 64'd0));
        tbl.push_back(mk(1'b0, 64'd0, 64'd0, S_RUN, 64'd1, 64'd0, 64'd0));
        tbl.push_back(mk(1'b0, 64'd0, 64'd0, S_TMO, 64'd1, 64'd0, 64'd0));
        tbl.push_back(mk(1'b0, 64'd5, 64'd3, S_TMO, 64'd1, 64'd0, 64'd0));
        tbl.push_back(mk(1'b1, 64'd0, 64'd0, S_RST, 64'd0, 64'd0, 64'd1));
        tbl.push_back(mk(1'b0, 64'd0, 64'd0, S_RST, 64'd0, 64'd0, 64'd1));
        tbl.push_back(mk(1'b0, 64'd0, 64'd0, S_RST, 64'd0, 64'd0, 64'd1));
        tbl.push_back(mk(1'b0, 64'd0, 64'd0, S_RUN, 64'd0, 64'd0, 64'd0));
        tbl.push_back(mk(1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, S_RUN,
                         64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'd0));
        tbl.push_back(mk(1'b0, 64'h20, 64'd0, S_RUN, ONES, 64'd0, 64'd0));
        tbl.push_back(mk(1'b0, 64'd1, 64'd0, S_RUN, ONES, 64'd0, 64'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            reset             = tbl[i].rst;
            bus.difftest_step = tbl[i].step;
            bus.difftest_exit = tbl[i].ext;
            tick();
            chk($sformatf("vec%0d state", i),      64'(bus.state),      tbl[i].st);
            chk($sformatf("vec%0d step_count", i), bus.step_count,      tbl[i].sc);
            chk($sformatf("vec%0d exit_code", i),  bus.exit_code,       tbl[i].ec);
            chk($sformatf("vec%0d dut_reset", i),  64'(bus.dut_reset),  tbl[i].dr);
            if (i == 0) begin
                chk("rst overflow",   64'(bus.uout_overflow),  64'd0);
                chk("rst pop_valid",  64'(bus.uout_pop_valid), 64'd0);
                chk("rst push_ready", 64'(bus.uin_push_ready), 64'd1);
            end
        end

        // Still in RUN with step=1 held so the watchdog stays quiet.
        bus.difftest_exit = 64'd0;
        bus.difftest_step = 64'd1;

        // UART-out: five pushes into a 4-deep FIFO, no pops -> 'E' dropped.
        for (int i = 0; i < 5; i++) begin
            bus.difftest_uart_out_valid = 1'b1;
            bus.difftest_uart_out_ch    = 8'h41 + 8'(i);
            tick();
            if (i == 3) begin
                chk("uout ovf before drop", 64'(bus.uout_overflow), 64'd0);
            end
        end
        bus.difftest_uart_out_valid = 1'b0;
        chk("uout ovf after drop", 64'(bus.uout_overflow), 64'd1);
        bus.uout_pop_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("uout pop%0d valid", i), 64'(bus.uout_pop_valid), 64'd1);
            chk($sformatf("uout pop%0d ch", i),    64'(bus.uout_pop_ch),    64'h41 + 64'(i));
            tick();
        end
        chk("uout drained valid", 64'(bus.uout_pop_valid), 64'd0);

        // UART-out: push while full and popping in the same cycle keeps both chars.
        bus.uout_pop_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.difftest_uart_out_valid = 1'b1;
            bus.difftest_uart_out_ch    = 8'h57 + 8'(i);
            tick();
        end
        bus.difftest_uart_out_ch = 8'h51;
        bus.uout_pop_ready       = 1'b1;
        chk("uout full head", 64'(bus.uout_pop_ch), 64'h57);
        tick();
        bus.difftest_uart_out_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("uout fp pop%0d ch", i), 64'(bus.uout_pop_ch),
                (i == 3) ? 64'h51 : 64'h58 + 64'(i));
            tick();
        end
        chk("uout fp drained", 64'(bus.uout_pop_valid), 64'd0);
        chk("uout ovf sticky", 64'(bus.uout_overflow),  64'd1);
        bus.uout_pop_ready = 1'b0;

        // Leave one char in UART-out for the mid-run reset check.
        bus.difftest_uart_out_valid = 1'b1;
        bus.difftest_uart_out_ch    = 8'h52;
        tick();
        bus.difftest_uart_out_valid = 1'b0;

        // UART-in: push into empty is not visible in the same cycle.
        bus.uin_push_valid         = 1'b1;
        bus.uin_push_ch            = 8'h41;
        bus.difftest_uart_in_valid = 1'b1;
        #1;
        chk("uin same-cycle", 64'(bus.difftest_uart_in_ch), 64'hFF);
        tick();
        bus.uin_push_valid = 1'b0;
        #1;
        chk("uin req1", 64'(bus.difftest_uart_in_ch), 64'h41);
        tick();
        chk("uin req2", 64'(bus.difftest_uart_in_ch), 64'hFF);
        tick();
        bus.difftest_uart_in_valid = 1'b0;

        // UART-in: fill all eight entries, ready drops when full.
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("uin ready%0d", i), 64'(bus.uin_push_ready), 64'd1);
            bus.uin_push_valid = 1'b1;
            bus.uin_push_ch    = 8'h60 + 8'(i);
            tick();
        end
        bus.uin_push_valid = 1'b0;
        #1;
        chk("uin full ready", 64'(bus.uin_push_ready), 64'd0);
        chk("uin no request", 64'(bus.difftest_uart_in_ch), 64'hFF);
        chk("pre-reset state", 64'(bus.state), S_RUN);
        chk("pre-reset pop_valid", 64'(bus.uout_pop_valid), 64'd1);

        // Mid-run reset: dut_reset follows reset at once, then everything clears.
        reset = 1'b1;
        #1;
        chk("midrst dut_reset comb", 64'(bus.dut_reset), 64'd1);
        tick();
        chk("midrst state",      64'(bus.state),          S_RST);
        chk("midrst step_count", bus.step_count,          64'd0);
        chk("midrst exit_code",  bus.exit_code,           64'd0);
        chk("midrst overflow",   64'(bus.uout_overflow),  64'd0);
        chk("midrst pop_valid",  64'(bus.uout_pop_valid), 64'd0);
        chk("midrst push_ready", 64'(bus.uin_push_ready), 64'd1);
        chk("midrst dut_reset",  64'(bus.dut_reset),      64'd1);
        reset = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
